// File: rtl/alu_decode_stage_if.sv
// Fetch/regfile/hazard inputs and ID/EX bundle of the ALU decode stage.
// The stage binds to the slave modport; its surroundings drive the master.
interface alu_decode_stage_if;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        stall;
    logic        flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        id_valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_data_1;
    logic [31:0] alu_data_2;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] store_data;
    logic        illegal_inst;
    logic        illegal_seen;

    modport master (
        output if_valid, if_inst, if_pc, stall, flush,
        output rs1_data, rs2_data,
        input  rs1_addr, rs2_addr,
        input  id_valid, alu_ctrl, alu_data_1, alu_data_2,
        input  rd_addr, reg_write, mem_read, mem_write,
        input  store_data, illegal_inst, illegal_seen
    );

    modport slave (
        input  if_valid, if_inst, if_pc, stall, flush,
        input  rs1_data, rs2_data,
        output rs1_addr, rs2_addr,
        output id_valid, alu_ctrl, alu_data_1, alu_data_2,
        output rd_addr, reg_write, mem_read, mem_write,
        output store_data, illegal_inst, illegal_seen
    );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: builds the ALU operand/control bundle
// and registers it into ID/EX with stall/flush handling.
module alu_decode_stage #(
    parameter int XLEN = 32
) (
    input logic clk,
    input logic rst,
    alu_decode_stage_if.slave bus
);
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        alu_op_e         ctrl;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic [4:0]      rd;
        logic            rw;
        logic            mr;
        logic            mw;
        logic [XLEN-1:0] sd;
    } id_ex_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [31:0]     inst;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic            is_shift;

    assign inst     = bus.if_inst;
    assign opc      = inst[6:0];
    assign f3       = inst[14:12];
    assign f7       = inst[31:25];
    assign imm_i    = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s    = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_u    = {inst[31:12], {(XLEN-20){1'b0}}};
    assign shamt    = {{(XLEN-5){1'b0}}, inst[24:20]};
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    assign bus.rs1_addr = inst[19:15];
    assign bus.rs2_addr = inst[24:20];

    function automatic alu_op_e f3_op(input logic [2:0] f);
        alu_op_e r;
        unique case (f)
            3'b000:  r = ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    id_ex_t dec;
    logic   legal;

    always_comb begin
        dec      = '0;
        legal    = 1'b0;
        dec.ctrl = ALU_ADD;
        dec.rd   = inst[11:7];
        dec.d1   = bus.rs1_data;
        dec.sd   = bus.rs2_data;
        unique case (1'b1)
            (opc == OPC_OP): begin
                dec.d2 = bus.rs2_data;
                dec.rw = 1'b1;
                if (f7 == F7_BASE) begin
                    legal    = 1'b1;
                    dec.ctrl = f3_op(f3);
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    legal    = 1'b1;
                    dec.ctrl = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    legal    = 1'b1;
                    dec.ctrl = ALU_SRA;
                end
            end
            (opc == OPC_IMM): begin
                dec.rw   = 1'b1;
                dec.ctrl = f3_op(f3);
                dec.d2   = imm_i;
                legal    = 1'b1;
                // shifts reuse imm[11:5] as funct7 and take shamt only
                if (is_shift) begin
                    dec.d2 = shamt;
                    legal  = (f7 == F7_BASE) ||
                             (f7 == F7_ALT && f3 == 3'b101);
                    if (f7 == F7_ALT) dec.ctrl = ALU_SRA;
                end
            end
            (opc == OPC_LUI): begin
                legal  = 1'b1;
                dec.rw = 1'b1;
                dec.d1 = '0;
                dec.d2 = imm_u;
            end
            (opc == OPC_AUIPC): begin
                legal  = 1'b1;
                dec.rw = 1'b1;
                dec.d1 = bus.if_pc;
                dec.d2 = imm_u;
            end
            (opc == OPC_LOAD): begin
                legal  = 1'b1;
                dec.rw = 1'b1;
                dec.mr = 1'b1;
                dec.d2 = imm_i;
            end
            (opc == OPC_STORE): begin
                legal  = 1'b1;
                dec.mw = 1'b1;
                dec.d2 = imm_s;
            end
            default: legal = 1'b0;
        endcase
        if (dec.rd == 5'd0) dec.rw = 1'b0;
    end

    id_ex_t q;
    logic   valid_q;
    logic   ill_q;
    logic   seen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
            q.rw    <= 1'b0;
            q.mr    <= 1'b0;
            q.mw    <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.if_valid && legal) begin
                q       <= dec;
                valid_q <= 1'b1;
                ill_q   <= 1'b0;
            end else begin
                // bubble; a dropped illegal word leaves only the flags
                valid_q <= 1'b0;
                ill_q   <= bus.if_valid;
                q.rw    <= 1'b0;
                q.mr    <= 1'b0;
                q.mw    <= 1'b0;
                if (bus.if_valid) seen_q <= 1'b1;
            end
        end
    end

    assign bus.id_valid     = valid_q;
    assign bus.alu_ctrl     = q.ctrl;
    assign bus.alu_data_1   = q.d1;
    assign bus.alu_data_2   = q.d2;
    assign bus.rd_addr      = q.rd;
    assign bus.reg_write    = q.rw;
    assign bus.mem_read     = q.mr;
    assign bus.mem_write    = q.mw;
    assign bus.store_data   = q.sd;
    assign bus.illegal_inst = ill_q;
    assign bus.illegal_seen = seen_q;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed vector table, hazard
// sequences and random traffic against a reference decoder.
module tb_alu_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_decode_stage_if ifc();
    alu_decode_stage #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    typedef struct {
        logic        valid;
        logic        ill;
        logic [3:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] sd;
    } out_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        out_t        e;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    out_t ms;
    logic mseen;
    out_t add_exp;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input out_t e, input logic seen);
        check({tag, ".valid"}, 32'(ifc.id_valid), 32'(e.valid));
        check({tag, ".ill"}, 32'(ifc.illegal_inst), 32'(e.ill));
        check({tag, ".seen"}, 32'(ifc.illegal_seen), 32'(seen));
        if (e.valid) begin
            check({tag, ".ctrl"}, 32'(ifc.alu_ctrl), 32'(e.ctrl));
            check({tag, ".d1"}, ifc.alu_data_1, e.d1);
            check({tag, ".d2"}, ifc.alu_data_2, e.d2);
            check({tag, ".rw"}, 32'(ifc.reg_write), 32'(e.rw));
            check({tag, ".mr"}, 32'(ifc.mem_read), 32'(e.mr));
            check({tag, ".mw"}, 32'(ifc.mem_write), 32'(e.mw));
            check({tag, ".sd"}, ifc.store_data, e.sd);
            if (e.rw) check({tag, ".rd"}, 32'(ifc.rd_addr), 32'(e.rd));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 32'(ifc.id_valid), 0);
        check({tag, ".ctrl"}, 32'(ifc.alu_ctrl), 0);
        check({tag, ".d1"}, ifc.alu_data_1, 0);
        check({tag, ".d2"}, ifc.alu_data_2, 0);
        check({tag, ".rd"}, 32'(ifc.rd_addr), 0);
        check({tag, ".ctl"}, {29'd0, ifc.reg_write, ifc.mem_read, ifc.mem_write}, 0);
        check({tag, ".sd"}, ifc.store_data, 0);
        check({tag, ".ill"}, 32'(ifc.illegal_inst), 0);
        check({tag, ".seen"}, 32'(ifc.illegal_seen), 0);
    endtask

    // Reference decoder: straight from the instruction-set rules.
    function automatic out_t model_decode(input logic [31:0] inst, pc, r1, r2);
        out_t        o;
        int          sel[8];
        logic [31:0] immi;
        logic [31:0] imms;
        logic [6:0]  f7;
        logic [2:0]  f3;
        bit          wr;
        sel  = '{0, 5, 8, 9, 2, 6, 3, 4};
        o    = '{default: '0};
        f7   = inst[31:25];
        f3   = inst[14:12];
        immi = 32'(inst[31:20]);
        if (inst[31]) immi = immi - 32'd4096;
        imms = 32'(inst[31:25]) * 32 + 32'(inst[11:7]);
        if (inst[31]) imms = imms - 32'd4096;
        wr   = 1'b1;
        o.rd = inst[11:7];
        o.sd = r2;
        o.d1 = r1;
        case (inst[6:0])
            7'h33: begin
                o.d2 = r2;
                if (f7 == 0) o.ctrl = 4'(sel[f3]);
                else if (f7 == 7'h20 && f3 == 0) o.ctrl = 4'd1;
                else if (f7 == 7'h20 && f3 == 5) o.ctrl = 4'd7;
                else o.ill = 1'b1;
            end
            7'h13: begin
                o.ctrl = 4'(sel[f3]);
                o.d2   = immi;
                if (f3 == 1 || f3 == 5) begin
                    o.d2 = 32'(inst[24:20]);
                    if (f7 == 7'h20 && f3 == 5) o.ctrl = 4'd7;
                    else if (f7 != 0) o.ill = 1'b1;
                end
            end
            7'h37: begin o.d1 = 0; o.d2 = inst & 32'hFFFFF000; end
            7'h17: begin o.d1 = pc; o.d2 = inst & 32'hFFFFF000; end
            7'h03: begin o.d2 = immi; o.mr = 1'b1; end
            7'h23: begin o.d2 = imms; o.mw = 1'b1; wr = 1'b0; end
            default: o.ill = 1'b1;
        endcase
        o.valid = !o.ill;
        o.rw    = wr && (o.rd != 0) && !o.ill;
        return o;
    endfunction

    task automatic step(input logic v, input logic [31:0] inst, pc, r1, r2,
                        input logic st, input logic fl);
        out_t d;
        @(negedge clk);
        ifc.if_valid = v;
        ifc.if_inst  = inst;
        ifc.if_pc    = pc;
        ifc.rs1_data = r1;
        ifc.rs2_data = r2;
        ifc.stall    = st;
        ifc.flush    = fl;
        #1;
        check("rs1_addr", 32'(ifc.rs1_addr), 32'(inst[19:15]));
        check("rs2_addr", 32'(ifc.rs2_addr), 32'(inst[24:20]));
        @(posedge clk);
        if (fl) begin
            ms.valid = 1'b0;
            ms.ill   = 1'b0;
        end else if (!st) begin
            if (!v) begin
                ms.valid = 1'b0;
                ms.ill   = 1'b0;
            end else begin
                d = model_decode(inst, pc, r1, r2);
                if (d.ill) begin
                    ms.valid = 1'b0;
                    ms.ill   = 1'b1;
                    mseen    = 1'b1;
                end else begin
                    ms = d;
                end
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h37;
            3: r[6:0] = 7'h17;
            4: r[6:0] = 7'h03;
            5: r[6:0] = 7'h23;
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{32'h002081B3, 32'h0, 32'd5, 32'd7,
                     '{1'b1, 1'b0, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'd7}};
        vecs[1]  = '{32'h40335293, 32'h0, 32'h80000000, 32'h0,
                     '{1'b1, 1'b0, 4'd7, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0}};
        vecs[2]  = '{32'h123450B7, 32'h0, 32'h55, 32'h66,
                     '{1'b1, 1'b0, 4'd0, 32'h0, 32'h12345000, 5'd1, 1'b1, 1'b0, 1'b0, 32'h66}};
        vecs[3]  = '{32'hFE20AE23, 32'h0, 32'h100, 32'hAB,
                     '{1'b1, 1'b0, 4'd0, 32'h100, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0, 1'b1, 32'hAB}};
        vecs[4]  = '{32'h40C58533, 32'h0, 32'd9, 32'd4,
                     '{1'b1, 1'b0, 4'd1, 32'd9, 32'd4, 5'd10, 1'b1, 1'b0, 1'b0, 32'd4}};
        vecs[5]  = '{32'h00500013, 32'h0, 32'h11, 32'h22,
                     '{1'b1, 1'b0, 4'd0, 32'h11, 32'd5, 5'd0, 1'b0, 1'b0, 1'b0, 32'h22}};
        vecs[6]  = '{32'hFFFFF397, 32'h1000, 32'h1, 32'h2,
                     '{1'b1, 1'b0, 4'd0, 32'h1000, 32'hFFFFF000, 5'd7, 1'b1, 1'b0, 1'b0, 32'h2}};
        vecs[7]  = '{32'hFF812403, 32'h0, 32'h2000, 32'h3,
                     '{1'b1, 1'b0, 4'd0, 32'h2000, 32'hFFFFFFF8, 5'd8, 1'b1, 1'b1, 1'b0, 32'h3}};
        vecs[8]  = '{32'hFFF0A213, 32'h0, 32'h1, 32'h0,
                     '{1'b1, 1'b0, 4'd8, 32'h1, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0}};
        vecs[9]  = '{32'h0000006F, 32'h0, 32'h0, 32'h0,
                     '{1'b0, 1'b1, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0}};
        vecs[10] = '{32'h022081B3, 32'h0, 32'h0, 32'h0,
                     '{1'b0, 1'b1, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0}};
        vecs[11] = '{32'h40209093, 32'h0, 32'h0, 32'h0,
                     '{1'b0, 1'b1, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0}};
        vecs[12] = '{32'h003130B3, 32'h0, 32'hFFFFFFFF, 32'h1,
                     '{1'b1, 1'b0, 4'd9, 32'hFFFFFFFF, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h1}};
        vecs[13] = '{32'h01F35293, 32'h0, 32'hF0F0F0F0, 32'h9,
                     '{1'b1, 1'b0, 4'd6, 32'hF0F0F0F0, 32'd31, 5'd5, 1'b1, 1'b0, 1'b0, 32'h9}};
        add_exp = vecs[0].e;

        ifc.if_valid = 1'b0;
        ifc.if_inst  = 32'h002081B3;
        ifc.if_pc    = 32'h0;
        ifc.rs1_data = 32'h0;
        ifc.rs2_data = 32'h0;
        ifc.stall    = 1'b0;
        ifc.flush    = 1'b0;
        ms           = '{default: '0};
        mseen        = 1'b0;

        // power-on reset
        @(negedge clk);
        check_zero("por");
        check("por.rs1_addr", 32'(ifc.rs1_addr), 32'd1);
        rst = 1'b0;

        begin
            logic seen_t;
            seen_t = 1'b0;
            for (int i = 0; i < 14; i++) begin
                step(1'b1, vecs[i].inst, vecs[i].pc, vecs[i].r1, vecs[i].r2, 1'b0, 1'b0);
                seen_t = seen_t | vecs[i].e.ill;
                check_out($sformatf("vec%0d", i), vecs[i].e, seen_t);
            end
        end

        // stall holds a valid add for three cycles
        step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        check_out("stall0", add_exp, mseen);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, rand_inst(), $urandom, $urandom, $urandom, 1'b1, 1'b0);
            check_out($sformatf("stall%0d", i + 1), add_exp, mseen);
        end

        step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b1);
        check("stflush.valid", 32'(ifc.id_valid), 0);
        check("stflush.ill", 32'(ifc.illegal_inst), 0);

        // illegal pulse then recovery; stall holds the pulse itself
        step(1'b1, 32'h0000006F, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("ill.pulse", 32'(ifc.illegal_inst), 1);
        check("ill.valid", 32'(ifc.id_valid), 0);
        step(1'b1, 32'h00000013, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("ill.hold", 32'(ifc.illegal_inst), 1);
        step(1'b1, 32'h00000013, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("ill.end", 32'(ifc.illegal_inst), 0);
        check("ill.nopvalid", 32'(ifc.id_valid), 1);
        check("ill.sticky", 32'(ifc.illegal_seen), 1);
        step(1'b0, 32'h0000006F, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("novalid.valid", 32'(ifc.id_valid), 0);
        check("novalid.ill", 32'(ifc.illegal_inst), 0);
        check("novalid.sticky", 32'(ifc.illegal_seen), 1);

        // asynchronous reset in the middle of a stall
        step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        check_out("prerst", add_exp, 1'b1);
        @(negedge clk);
        ifc.stall = 1'b1;
        #2 rst = 1'b1;
        #1 check_zero("midrst");
        @(negedge clk);
        rst       = 1'b0;
        ifc.stall = 1'b0;
        ms        = '{default: '0};
        mseen     = 1'b0;

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, rand_inst(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
            check_out($sformatf("rnd%0d", i), ms, mseen);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
